// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by uart_tx and the future uart_rx.
package uart_pkg;

    // 50 MHz clock / 50 = 1 Mbaud.
    localparam int unsigned CLK_PER_BIT_DEFAULT = 50;

    // StParity is only reachable when UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Parity bit for one byte: even parity when odd == 0, odd parity when odd == 1.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the message printer (master) and uart_tx (slave).
interface uart_tx_if;
    logic [7:0] data;
    logic       new_data;
    logic       busy;

    modport master (
        output data,
        output new_data,
        input  busy
    );

    modport slave (
        input  data,
        input  new_data,
        output busy
    );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Two stages of pure delay; the first flop may go metastable.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, 8N1 by default.
// Define UART_TX_PARITY_EN to insert a parity bit (polarity from PARITY_ODD) before the stop bit.
// tx and busy are registered and derived from the next state, so they change on the
// same edge as the state they describe.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave host,
    input  logic     block,
    output logic     tx
);
    localparam int unsigned     CtrW   = $clog2(CLK_PER_BIT);
    localparam logic [CtrW-1:0] CtrMax = CtrW'(CLK_PER_BIT - 1);

    if (CLK_PER_BIT < 2 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx: CLK_PER_BIT must be >= 2 and PARITY_ODD must be 0 or 1");
    end

    uart_state_e     state_q, state_d;
    logic [CtrW-1:0] ctr_q, ctr_d, ctr_next;
    logic [2:0]      bit_ctr_q, bit_ctr_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            block_s;
    logic            bit_end;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
    localparam uart_state_e AfterData = StParity;
`else
    localparam uart_state_e AfterData = StStop;
`endif

    sync_2ff #(
        .WIDTH (1)
    ) u_block_sync (
        .clk (clk),
        .rst (rst),
        .d   (block),
        .q   (block_s)
    );

    assign bit_end  = (ctr_q == CtrMax);
    assign ctr_next = bit_end ? '0 : ctr_q + 1'b1;

    // Next-state, counters, shift register and registered outputs.
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        bit_ctr_d = bit_ctr_q;
        shreg_d   = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                // busy_q (not busy_d) gates accept, so a strobe in the cycle busy falls wins.
                if (host.new_data && !block_s && !busy_q) begin
                    shreg_d   = host.data;
                    ctr_d     = '0;
                    bit_ctr_d = '0;
                    state_d   = StStart;
`ifdef UART_TX_PARITY_EN
                    // Computed at accept because the shift register is consumed later.
                    par_d     = parity_bit(host.data, PARITY_ODD != 0);
`endif
                end
            end
            StStart: begin
                ctr_d = ctr_next;
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                ctr_d = ctr_next;
                if (bit_end) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_ctr_d = bit_ctr_q + 3'd1;
                    if (bit_ctr_q == 3'd7) begin
                        state_d = AfterData;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                ctr_d = ctr_next;
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                ctr_d = ctr_next;
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != StIdle) || block_s;
    end

    // FSM and output registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ctr_q     <= '0;
            bit_ctr_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            bit_ctr_q <= bit_ctr_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign host.busy = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CLK_PER_BIT = 4.
// Expected line levels come from a bit-list frame model (start, data LSB first,
// optional parity, stop), each bit held CPB cycles.
module tb_uart_tx;
    localparam int unsigned CPB     = 4;
    localparam int unsigned PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FL = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par_even;  // hand-computed even-parity bit
    } vec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic block = 1'b0;
    logic tx;
    int   tests = 0;
    int   fails = 0;

    uart_tx_if host ();

    uart_tx #(
        .CLK_PER_BIT (CPB),
        .PARITY_ODD  (PAR_ODD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .host  (host),
        .block (block),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: index k is the level of bit k on the line.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[1 + i] = d[i];
            ones += int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        f[9] = ((ones % 2) == 1) ^ (PAR_ODD != 0);
`endif
        return f;
    endfunction

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            check({name, " idle tx"}, 32'(tx), 32'd1);
            check({name, " idle busy"}, 32'(host.busy), 32'd0);
            step();
        end
    endtask

    // Send one byte starting just after an edge where busy is low, then check the whole frame.
    // kind 1: strobe 0xAA at cycle inj_k (must be ignored); kind 2: raise block at cycle inj_k.
    task automatic run_frame(input logic [7:0] d, input logic [10:0] f, input int inj_k,
                             input int kind, input string name);
        host.data     = d;
        host.new_data = 1'b1;
        step();
        host.new_data = 1'b0;
        host.data     = 8'($urandom);
        for (int k = 0; k < int'(FL); k++) begin
            check($sformatf("%s tx[%0d]", name, k), 32'(tx), 32'(f[k / int'(CPB)]));
            check($sformatf("%s busy[%0d]", name, k), 32'(host.busy), 32'd1);
            if (k == inj_k && kind == 1) begin
                host.data     = 8'hAA;
                host.new_data = 1'b1;
            end
            if (k == inj_k && kind == 2) begin
                block = 1'b1;
            end
            step();
            host.new_data = 1'b0;
        end
        check({name, " end tx"}, 32'(tx), 32'd1);
        if (kind == 2) begin
            check({name, " busy held by block"}, 32'(host.busy), 32'd1);
            block = 1'b0;
            step();
            step();
            check({name, " busy 2 after release"}, 32'(host.busy), 32'd1);
            step();
            check({name, " busy 3 after release"}, 32'(host.busy), 32'd0);
        end else begin
            check({name, " end busy"}, 32'(host.busy), 32'd0);
        end
    endtask

    initial begin
        vec_t        tbl[10];
        logic [10:0] f;
        logic [7:0]  d;

        tbl[0] = '{8'h68, 1'b1};
        tbl[1] = '{8'h00, 1'b0};
        tbl[2] = '{8'hFF, 1'b0};
        tbl[3] = '{8'h01, 1'b1};
        tbl[4] = '{8'h80, 1'b1};
        tbl[5] = '{8'h55, 1'b0};
        tbl[6] = '{8'hA5, 1'b0};
        tbl[7] = '{8'h7F, 1'b1};
        tbl[8] = '{8'h3C, 1'b0};
        tbl[9] = '{8'h81, 1'b0};

        host.data     = 8'h00;
        host.new_data = 1'b0;
        rst           = 1'b1;
        repeat (3) step();
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(host.busy), 32'd0);
        rst = 1'b0;
        idle(4, "post-reset");

        // Table vectors; gap of 0 cycles exercises back-to-back accept when busy falls.
        for (int i = 0; i < 10; i++) begin
            f = frame_of(tbl[i].data);
`ifdef UART_TX_PARITY_EN
            f[9] = tbl[i].par_even ^ (PAR_ODD != 0);
`endif
            run_frame(tbl[i].data, f, -1, 0, $sformatf("vec%0d", i));
            idle(i % 3, $sformatf("vec%0d", i));
        end

        // Explicit back-to-back: 0x55 strobed in the cycle busy falls.
        run_frame(8'h68, frame_of(8'h68), -1, 0, "b2b first");
        run_frame(8'h55, frame_of(8'h55), -1, 0, "b2b second");

        // Randomized bytes against the frame model.
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            run_frame(d, frame_of(d), -1, 0, $sformatf("rand%0d", i));
            idle(int'($urandom_range(0, 2)), "rand");
        end

        // Strobe while busy mid-frame: ignored, no second frame.
        run_frame(8'h68, frame_of(8'h68), 2 * int'(CPB) + 1, 1, "ignore");
        idle(2 * int'(FL), "ignore after");

        // block held: busy rises 3 cycles later, strobes ignored; release then send.
        block = 1'b1;
        step();
        step();
        check("block busy at +2", 32'(host.busy), 32'd0);
        step();
        check("block busy at +3", 32'(host.busy), 32'd1);
        host.data     = 8'h11;
        host.new_data = 1'b1;
        step();
        host.new_data = 1'b0;
        for (int i = 0; i < int'(FL); i++) begin
            check("blocked tx", 32'(tx), 32'd1);
            check("blocked busy", 32'(host.busy), 32'd1);
            step();
        end
        block = 1'b0;
        step();
        step();
        check("unblock busy at +2", 32'(host.busy), 32'd1);
        step();
        check("unblock busy at +3", 32'(host.busy), 32'd0);
        run_frame(8'h3C, frame_of(8'h3C), -1, 0, "after unblock");

        // block rising mid-frame: frame completes, busy held until block_s falls.
        run_frame(8'hA5, frame_of(8'hA5), 3 * int'(CPB), 2, "block mid");
        idle(3, "block mid");

        // Reset during data bit 3 aborts the frame.
        f             = frame_of(8'h68);
        host.data     = 8'h68;
        host.new_data = 1'b1;
        step();
        host.new_data = 1'b0;
        for (int k = 0; k < 4 * int'(CPB) + 1; k++) begin
            step();
        end
        check("pre-reset bit3", 32'(tx), 32'(f[4]));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid-reset tx", 32'(tx), 32'd1);
        check("mid-reset busy", 32'(host.busy), 32'd0);
        idle(int'(FL), "after reset");
        run_frame(8'h01, frame_of(8'h01), -1, 0, "post-reset 0x01");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
